// File: rtl/dmem_responder.sv
// Word-addressed data-memory target for the CPU load/store port.
// One outstanding transaction, programmable wait states, byte strobes, error and access statistics.
module dmem_responder #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_1000,
    parameter int unsigned LATENCY     = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_wstrb,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic [31:0] acc_count,
    output logic [15:0] err_count
);
    localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);
    localparam int unsigned CNT_W = 4;
    localparam logic [CNT_W-1:0] WAIT_INIT = CNT_W'((LATENCY > 0) ? (LATENCY - 1) : 0);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_RESP
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               lat_we_q, lat_we_d;
    logic [31:0]        lat_addr_q, lat_addr_d;
    logic [31:0]        lat_wdata_q, lat_wdata_d;
    logic [3:0]         lat_wstrb_q, lat_wstrb_d;
    logic               req_ready_q, req_ready_d;
    logic               rsp_valid_q, rsp_valid_d;
    logic [31:0]        rsp_rdata_q, rsp_rdata_d;
    logic               rsp_err_q, rsp_err_d;
    logic [31:0]        acc_count_q, acc_count_d;
    logic [15:0]        err_count_q, err_count_d;

    logic [31:0]        mem [DEPTH_WORDS];

    // Commit operands: live request on a zero-latency accept, latched copy otherwise
    logic               c_we;
    logic [31:0]        c_addr;
    logic [31:0]        c_wdata;
    logic [3:0]         c_wstrb;
    logic [29:0]        c_word;
    logic [IDX_W-1:0]   c_idx;
    logic               c_err;
    logic               commit_c;

    always_comb begin
        if (state_q == ST_IDLE) begin
            c_we    = req_we;
            c_addr  = req_addr;
            c_wdata = req_wdata;
            c_wstrb = req_wstrb;
        end else begin
            c_we    = lat_we_q;
            c_addr  = lat_addr_q;
            c_wdata = lat_wdata_q;
            c_wstrb = lat_wstrb_q;
        end
        c_word = c_addr[31:2] - BASE_ADDR[31:2];
        c_idx  = c_word[IDX_W-1:0];
        c_err  = (c_addr[1:0] != 2'b00) || (c_addr < BASE_ADDR) ||
                 ({2'b00, c_word} >= 32'(DEPTH_WORDS));
    end

    // Next-state and registered-output logic
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        lat_we_d    = lat_we_q;
        lat_addr_d  = lat_addr_q;
        lat_wdata_d = lat_wdata_q;
        lat_wstrb_d = lat_wstrb_q;
        rsp_valid_d = rsp_valid_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        acc_count_d = acc_count_q;
        err_count_d = err_count_q;
        commit_c    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (req_ready_q && req_valid) begin
                    lat_we_d    = req_we;
                    lat_addr_d  = req_addr;
                    lat_wdata_d = req_wdata;
                    lat_wstrb_d = req_wstrb;
                    if (LATENCY == 0) begin
                        commit_c = 1'b1;
                        state_d  = ST_RESP;
                    end else begin
                        cnt_d   = WAIT_INIT;
                        state_d = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (cnt_q == '0) begin
                    commit_c = 1'b1;
                    state_d  = ST_RESP;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    acc_count_d = acc_count_q + 32'd1;
                    err_count_d = err_count_q + 16'(rsp_err_q);
                    rsp_valid_d = 1'b0;
                    rsp_rdata_d = 32'd0;
                    rsp_err_d   = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (commit_c) begin
            rsp_valid_d = 1'b1;
            rsp_err_d   = c_err;
            rsp_rdata_d = (!c_we && !c_err) ? mem[c_idx] : 32'd0;
        end

        req_ready_d = (state_d == ST_IDLE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            lat_we_q    <= 1'b0;
            lat_addr_q  <= 32'd0;
            lat_wdata_q <= 32'd0;
            lat_wstrb_q <= 4'd0;
            req_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= 32'd0;
            rsp_err_q   <= 1'b0;
            acc_count_q <= 32'd0;
            err_count_q <= 16'd0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            lat_we_q    <= lat_we_d;
            lat_addr_q  <= lat_addr_d;
            lat_wdata_q <= lat_wdata_d;
            lat_wstrb_q <= lat_wstrb_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
            acc_count_q <= acc_count_d;
            err_count_q <= err_count_d;
        end
    end

    // Storage is deliberately not reset; errored stores never reach it
    always_ff @(posedge clk) begin
        if (commit_c && c_we && !c_err) begin
            for (int i = 0; i < 4; i++) begin
                if (c_wstrb[i]) mem[c_idx][8*i +: 8] <= c_wdata[8*i +: 8];
            end
        end
    end

    assign req_ready = req_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;
    assign acc_count = acc_count_q;
    assign err_count = err_count_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: LATENCY=2 main instance plus LATENCY=0 and LATENCY=15 instances.
module tb_dmem_responder;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_we, rsp_ready;
    logic [31:0] req_addr, req_wdata;
    logic [3:0]  req_wstrb;
    logic        req_ready, rsp_valid, rsp_err;
    logic [31:0] rsp_rdata, acc_count;
    logic [15:0] err_count;

    logic        b_valid, b_we, b_rsp_ready;
    logic [31:0] b_addr, b_wdata;
    logic [3:0]  b_wstrb;
    logic        r0_ready, r0_valid, r0_err, r15_ready, r15_valid, r15_err;
    logic [31:0] r0_rdata, r0_acc, r15_rdata, r15_acc;
    logic [15:0] r0_errc, r15_errc;

    int checks = 0;
    int failures = 0;
    int exp_acc = 0;
    int exp_errc = 0;

    always #5 clk = ~clk;

    dmem_responder #(.DEPTH_WORDS(1024), .BASE_ADDR(32'h1000), .LATENCY(2)) dut (
        .clk(clk), .reset(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .acc_count(acc_count), .err_count(err_count));

    dmem_responder #(.DEPTH_WORDS(1024), .BASE_ADDR(32'h1000), .LATENCY(0)) dut0 (
        .clk(clk), .reset(rst_n), .req_valid(b_valid), .req_ready(r0_ready),
        .req_we(b_we), .req_addr(b_addr), .req_wdata(b_wdata), .req_wstrb(b_wstrb),
        .rsp_valid(r0_valid), .rsp_ready(b_rsp_ready), .rsp_rdata(r0_rdata), .rsp_err(r0_err),
        .acc_count(r0_acc), .err_count(r0_errc));

    dmem_responder #(.DEPTH_WORDS(1024), .BASE_ADDR(32'h1000), .LATENCY(15)) dut15 (
        .clk(clk), .reset(rst_n), .req_valid(b_valid), .req_ready(r15_ready),
        .req_we(b_we), .req_addr(b_addr), .req_wdata(b_wdata), .req_wstrb(b_wstrb),
        .rsp_valid(r15_valid), .rsp_ready(b_rsp_ready), .rsp_rdata(r15_rdata), .rsp_err(r15_err),
        .acc_count(r15_acc), .err_count(r15_errc));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drive a request from a negedge, wait for accept, measure latency, handshake the response
    task automatic xact(input string tag, input logic we, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [3:0] wstrb,
                        input logic [31:0] exp_rdata, input logic exp_err);
        int guard;
        int lat;
        req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata; req_wstrb = wstrb;
        guard = 0;
        while (!req_ready && guard < 50) begin @(negedge clk); guard++; end
        chk({tag, "_accept_timeout"}, 32'(guard < 50), 32'd1);
        @(posedge clk);
        lat = 1;
        @(negedge clk);
        req_valid = 1'b0; req_we = ~we; req_addr = 32'hFFFF_FFFF; req_wdata = 32'h5A5A_5A5A; req_wstrb = 4'hF;
        while (!rsp_valid && lat < 40) begin @(posedge clk); lat++; @(negedge clk); end
        chk({tag, "_latency"}, 32'(lat), 32'd3);
        chk({tag, "_rdata"}, rsp_rdata, exp_rdata);
        chk({tag, "_err"}, 32'(rsp_err), 32'(exp_err));
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rsp_ready = 1'b0;
        exp_acc++;
        if (exp_err) exp_errc++;
    endtask

    initial begin
        int guard;
        int lat;
        int lat0;
        int lat15;
        logic stable_ok;

        rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = 32'd0; req_wdata = 32'd0;
        req_wstrb = 4'd0; rsp_ready = 1'b0;
        b_valid = 1'b0; b_we = 1'b0; b_addr = 32'd0; b_wdata = 32'd0; b_wstrb = 4'd0; b_rsp_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rdata_err", {rsp_rdata[30:0], rsp_err}, 32'd0);
        chk("rst_counters", acc_count | 32'(err_count), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("ready_after_release", 32'(req_ready), 32'd1);

        xact("st_1000", 1'b1, 32'h1000, 32'hDEAD_BEEF, 4'hF, 32'h0, 1'b0);
        xact("ld_1000", 1'b0, 32'h1000, 32'h0, 4'h0, 32'hDEAD_BEEF, 1'b0);
        chk("acc_after_two", acc_count, 32'd2);

        xact("st_1004_full", 1'b1, 32'h1004, 32'h1122_3344, 4'hF, 32'h0, 1'b0);
        xact("st_1004_strb5", 1'b1, 32'h1004, 32'hAABB_CCDD, 4'h5, 32'h0, 1'b0);
        xact("ld_1004", 1'b0, 32'h1004, 32'h0, 4'h0, 32'h11BB_33DD, 1'b0);
        xact("st_1004_strb0", 1'b1, 32'h1004, 32'hFFFF_FFFF, 4'h0, 32'h0, 1'b0);
        xact("ld_1004_again", 1'b0, 32'h1004, 32'h0, 4'h0, 32'h11BB_33DD, 1'b0);
        xact("st_1ffc", 1'b1, 32'h1FFC, 32'hCAFE_F00D, 4'hF, 32'h0, 1'b0);
        xact("st_1008_zero", 1'b1, 32'h1008, 32'h0, 4'hF, 32'h0, 1'b0);

        xact("ld_misaligned", 1'b0, 32'h1002, 32'h0, 4'h0, 32'h0, 1'b1);
        xact("st_below", 1'b1, 32'h0FFC, 32'h0BAD_0BAD, 4'hF, 32'h0, 1'b1);
        xact("ld_above", 1'b0, 32'h2000, 32'h0, 4'h0, 32'h0, 1'b1);
        chk("err_count_three", 32'(err_count), 32'd3);
        xact("st_above", 1'b1, 32'h2000, 32'h5555_5555, 4'hF, 32'h0, 1'b1);
        xact("ld_1ffc", 1'b0, 32'h1FFC, 32'h0, 4'h0, 32'hCAFE_F00D, 1'b0);
        xact("ld_1000_noalias", 1'b0, 32'h1000, 32'h0, 4'h0, 32'hDEAD_BEEF, 1'b0);
        chk("acc_count", acc_count, 32'(exp_acc));
        chk("err_count", 32'(err_count), 32'(exp_errc));

        // Back-pressure: second request held valid while the first response waits
        req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h1000; req_wstrb = 4'h0;
        @(posedge clk);
        @(negedge clk);
        req_addr = 32'h1004;
        guard = 0;
        while (!rsp_valid && guard < 20) begin @(negedge clk); guard++; end
        chk("bp_rsp_seen", 32'(rsp_valid), 32'd1);
        stable_ok = 1'b1;
        for (int i = 0; i < 7; i++) begin
            if (!(rsp_valid && rsp_rdata == 32'hDEAD_BEEF && !rsp_err && !req_ready)) stable_ok = 1'b0;
            @(negedge clk);
        end
        chk("bp_stable_and_blocked", 32'(stable_ok), 32'd1);
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rsp_ready = 1'b0;
        chk("bp_ready_after_hs", {30'd0, req_ready, rsp_valid}, 32'd2);
        @(posedge clk);
        lat = 1;
        @(negedge clk);
        req_valid = 1'b0;
        while (!rsp_valid && lat < 40) begin @(posedge clk); lat++; @(negedge clk); end
        chk("bp_second_latency", 32'(lat), 32'd3);
        chk("bp_second_rdata", rsp_rdata, 32'h11BB_33DD);
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rsp_ready = 1'b0;
        exp_acc += 2;
        chk("bp_acc", acc_count, 32'(exp_acc));

        // Reset during WAIT abandons an uncommitted store
        req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h1008; req_wdata = 32'h9999_9999; req_wstrb = 4'hF;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("mid_rst_counters", acc_count | 32'(err_count), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        exp_acc = 0; exp_errc = 0;
        xact("ld_1008_after_rst", 1'b0, 32'h1008, 32'h0, 4'h0, 32'h0, 1'b0);

        // Reset in RESP keeps a committed store
        req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h100C; req_wdata = 32'h0F0F_A5A5; req_wstrb = 4'hF;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        guard = 0;
        while (!rsp_valid && guard < 20) begin @(negedge clk); guard++; end
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        xact("ld_100c_committed", 1'b0, 32'h100C, 32'h0, 4'h0, 32'h0F0F_A5A5, 1'b0);
        chk("acc_after_rst", acc_count, 32'd1);

        // Latency extremes on the LATENCY=0 and LATENCY=15 instances
        b_valid = 1'b1; b_we = 1'b1; b_addr = 32'h1010; b_wdata = 32'h1234_5678; b_wstrb = 4'hF;
        guard = 0;
        while (!(r0_ready && r15_ready) && guard < 20) begin @(negedge clk); guard++; end
        @(posedge clk);
        @(negedge clk);
        b_valid = 1'b0;
        lat0 = 0; lat15 = 0;
        for (int k = 1; k <= 25; k++) begin
            if (r0_valid && lat0 == 0) lat0 = k;
            if (r15_valid && lat15 == 0) lat15 = k;
            @(negedge clk);
        end
        chk("lat0_latency", 32'(lat0), 32'd1);
        chk("lat15_latency", 32'(lat15), 32'd16);
        chk("lat_counts", r0_acc + r15_acc, 32'd2);
        chk("lat0_ready_back", 32'(r0_ready), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Word-addressed data-memory responder. It serves the CPU load/store unit's request/response handshake, acting as the target side of the CPU's data-memory port.
- Models configurable wait states, byte-strobed writes, alignment and range error reporting, and access statistics.
- Sits beside the CPU inside the top-level simulation/FPGA build.
- Supports one outstanding transaction at a time.

Parameters:
- DEPTH_WORDS, 1024: number of 32-bit words stored; must be a power of two, minimum 4.
- BASE_ADDR, 32'h0000_1000: byte address of word 0; must be aligned to DEPTH_WORDS*4.
- LATENCY, 2: wait cycles inserted between request accept and response; legal range 0..15.

Ports:
- clk  input  1  system clock, rising-edge active
- reset  input  1  asynchronous, active-low reset (0 = in reset)
- req_valid  input  1  CPU presents a request
- req_ready  output  1  responder can accept a request
- req_we  input  1  1 = store, 0 = load
- req_addr  input  32  byte address
- req_wdata  input  32  store data
- req_wstrb  input  4  byte enables; bit i enables wdata[8i+7:8i]
- rsp_valid  output  1  response available
- rsp_ready  input  1  CPU accepts the response
- rsp_rdata  output  32  load data (0 for stores and errors)
- rsp_err  output  1  misaligned or out-of-range access
- acc_count  output  32  completed responses, including errors
- err_count  output  16  completed responses with rsp_err=1

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE; req_ready=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, acc_count=0, err_count=0.
  - Memory array contents are not reset.
  - req_ready rises on the first rising edge after reset is released.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - req_ready=1 (registered).
  - On a rising edge with req_valid=1, the request is accepted: latch we, addr, wdata, wstrb and drop req_ready.
  - Next state is WAIT with wait counter loaded to LATENCY-1 when LATENCY>0; next state is RESP when LATENCY=0.
- WAIT:
  - Counter decrements each cycle.
  - At the edge where the counter is 0, enter RESP.
- Entry into RESP (single commit edge):
  - Error check: err = (addr[1:0]!=0) | (addr < BASE_ADDR) | (((addr-BASE_ADDR)>>2) >= DEPTH_WORDS).
  - Store without error: write only the bytes enabled by wstrb. wstrb=0 is legal: no bytes are written, no error.
  - Load without error: rsp_rdata = mem[(addr-BASE_ADDR)>>2].
  - Store, or any errored access: rsp_rdata=0.
  - Errored access writes nothing.
  - rsp_valid=1, rsp_err=err.
- Latency: rsp_valid first high exactly LATENCY+1 cycles after the accept edge.
- RESP:
  - rsp_valid, rsp_rdata and rsp_err are held stable until rsp_ready=1 at a rising edge.
  - On that edge: acc_count += 1; err_count += rsp_err; rsp_valid, rsp_rdata and rsp_err clear to 0; go to IDLE.
  - req_ready is high from the cycle after the response handshake.
- Throughput: at most one transaction per LATENCY+3 cycles. Requests are never accepted while a response is pending.
- req_* inputs are ignored outside IDLE. Changing them after accept has no effect on the transaction.
- rsp_ready outside RESP is ignored.
- Counters wrap modulo 2^32 and 2^16 respectively, with no saturation.
- Reset asserted mid-transaction:
  - The transaction is abandoned and no response is issued.
  - A store not yet committed is not performed.
  - A store already committed (state RESP) remains in memory.
- Read-after-write: a load issued after a store handshake returns the new data.

Test Plan (DEPTH_WORDS=1024, BASE_ADDR=0x1000, LATENCY=2 unless stated):
- Reset release then store 0x1000, wdata=0xDEADBEEF, wstrb=0xF -> rsp_valid 3 cycles after accept, rsp_err=0, rsp_rdata=0; load 0x1000 -> rsp_rdata=0xDEADBEEF; acc_count=2.
- Store 0x1004 wdata=0x11223344 wstrb=0xF, then store 0x1004 wdata=0xAABBCCDD wstrb=0x5, then load 0x1004 -> 0x11BB33DD.
- Load 0x1002 (misaligned), store 0x0FFC and load 0x2000 (out of range) -> rsp_err=1, rsp_rdata=0 for all three; memory at 0x1FFC unchanged; err_count=3.
- Hold rsp_ready=0 for 7 cycles while req_valid=1 with a new request -> rsp_valid/rdata stable, req_ready=0, second request accepted only in IDLE after the handshake.
- LATENCY=0 build: accept edge -> rsp_valid next cycle; LATENCY=15 build -> rsp_valid 16 cycles after accept.
- Assert reset in WAIT of a store to 0x1008 (prior value 0x0) -> rsp_valid=0 at once, counters=0; after release, load 0x1008 -> 0x00000000.
